uart_autobaud: RTL and testbench
================================

// Module: uart_autobaud
// PURPOSE
// - Baud-rate controller for the UART receive path: generates the 16x sample_tick that clocks the receiver.
// - Holds a programmable divisor and can auto-calibrate it by timing a host-sent 0x55 sync character.
// - Gates the receiver via rx_enable while calibrating. Sits between the RX synchronizer and the receiver.
// PARAMETERS
// - DIV_WIDTH   16  width of divisor (uart_clk cycles per sample_tick)
// - DEFAULT_DIV 27  divisor after reset (115200 baud x16 at 50 MHz)
// - MIN_DIV     4   smallest divisor accepted from calibration or div_wr
// PORTS
// - uart_clk       in   1          clock, all logic on rising edge
// - rst            in   1          asynchronous reset, active-high
// - rx_serial_sync in   1          synchronized RX line, idle high
// - cal_start      in   1          1-cycle pulse: begin calibration
// - div_wr         in   1          1-cycle pulse: load div_wdata as divisor
// - div_wdata      in   DIV_WIDTH  manual divisor value
// - sample_tick    out  1          1-cycle pulse every `divisor` cycles (16x baud)
// - divisor        out  DIV_WIDTH  current divisor
// - rx_enable      out  1          high when receiver may run; low during calibration
// - cal_busy       out  1          calibration in progress
// - locked         out  1          divisor set by successful calibration or div_wr
// - cal_error      out  1          sticky: last calibration failed; cleared by cal_start or div_wr
// BEHAVIOUR
// - Reset: divisor=DEFAULT_DIV, sample_tick=0, rx_enable=1, cal_busy=0, locked=0, cal_error=0, state IDLE, prescaler=0.
// - Reset asserted mid-calibration: abort immediately to the reset values above, no divisor update.
// - Tick gen: prescaler counts 0..divisor-1; sample_tick=1 in the cycle prescaler==divisor-1, then wraps to 0.
// - sample_tick forced 0 while cal_busy. Any divisor change zeroes the prescaler (first tick divisor cycles later).
// - div_wr: if div_wdata>=MIN_DIV: divisor<=div_wdata, locked=1, cal_error=0; else ignored (no state change).
// - div_wr in any calibration state aborts calibration -> IDLE (div_wr result applies).
// - div_wr and cal_start in the same cycle: div_wr wins, cal_start is dropped.
// - cal_start is ignored unless state==IDLE.
// - Edge detect: rx_prev register; fall = rx_prev & ~rx_serial_sync; rise = ~rx_prev & rx_serial_sync.
// - Measurement counter mcnt: DIV_WIDTH+7 bits; saturates at all-ones.
// - FSM:
//   IDLE       : cal_start -> WAIT_HIGH; cal_busy=1, rx_enable=0, cal_error=0, locked=0.
//   WAIT_HIGH  : line must be high (no partial frame). rx_serial_sync==1 -> WAIT_START.
//   WAIT_START : fall -> MEASURE; mcnt=1, edge_cnt=1. Waits indefinitely (host-timed).
//   MEASURE    : mcnt++ each cycle; on fall edge_cnt++. Fifth fall (edge_cnt 4->5) -> WAIT_STOP, mcnt frozen.
//   WAIT_STOP  : rise -> APPLY. Line low for more than 8*MIN_DIV*16 cycles -> FAIL.
//   APPLY      : one cycle. div=(mcnt+64)>>7 (round to nearest; 8 bit-times x 16 ticks).
//                div>=MIN_DIV and div fits DIV_WIDTH -> divisor=div, locked=1; else cal_error=1.
//                Either way -> IDLE.
//   FAIL       : cal_error=1, divisor unchanged -> IDLE.
// - mcnt saturating in MEASURE -> FAIL (timeout).
// - In IDLE: cal_busy=0 and rx_enable=1.
// - Fall positions for 0x55 (8N1 LSB-first): bits 0,2,4,6,8. So first-to-fifth fall spans exactly 8 bit periods.
// - locked stays 1 across idle; cleared only by cal_start or reset.
// TESTING
// - Reset: check divisor=27, locked=0, rx_enable=1. Tick every 27 cycles, first tick 27 cycles after rst drops.
// - Calibration, bit period 160 clk, 0x55 sent -> mcnt=1280, divisor=10, locked=1. Ticks every 10 clk. rx_enable low only during cal.
// - Calibration, bit period 434 clk -> divisor=27; bit period 437 clk (mcnt=3496) -> divisor=27 (rounding check).
// - Too fast, bit period 8 clk -> div=1<MIN_DIV -> cal_error=1, divisor unchanged, locked=0.
// - cal_start then line held low after first fall -> mcnt saturates -> cal_error=1, back to IDLE, rx_enable=1.
// - div_wr=50 mid-MEASURE -> abort, divisor=50, locked=1, prescaler restarts.
//   div_wr=3 -> ignored.
//   div_wr+cal_start same cycle -> no calibration.
//   rst mid-MEASURE -> reset values.

Source files
------------

// File: rtl/uart_autobaud.sv
// Baud-rate controller for the UART receive path.
// Generates the 16x sample_tick for the receiver from a programmable divisor, and can
// auto-calibrate that divisor by timing a host-sent 0x55 sync character.
// Ports:
//   uart_clk, rst         clock (rising edge), asynchronous active-high reset
//   rx_serial_sync        synchronized RX line, idle high
//   cal_start             1-cycle pulse, start calibration (only accepted in idle)
//   div_wr, div_wdata     1-cycle pulse, load a manual divisor (values below MIN_DIV ignored)
//   sample_tick           1-cycle pulse every `divisor` cycles, suppressed while calibrating
//   divisor               current divisor
//   rx_enable             receiver may run (low while calibrating)
//   cal_busy              calibration in progress
//   locked                divisor came from a successful calibration or div_wr
//   cal_error             sticky, last calibration failed
module uart_autobaud #(
  parameter int unsigned DIV_WIDTH   = 16,
  parameter int unsigned DEFAULT_DIV = 27,
  parameter int unsigned MIN_DIV     = 4
) (
  input  logic                 uart_clk,
  input  logic                 rst,
  input  logic                 rx_serial_sync,
  input  logic                 cal_start,
  input  logic                 div_wr,
  input  logic [DIV_WIDTH-1:0] div_wdata,
  output logic                 sample_tick,
  output logic [DIV_WIDTH-1:0] divisor,
  output logic                 rx_enable,
  output logic                 cal_busy,
  output logic                 locked,
  output logic                 cal_error
);

  localparam int unsigned McntW    = DIV_WIDTH + 7;
  localparam int unsigned LowLimit = 8 * MIN_DIV * 16;
  localparam int unsigned LcntW    = $clog2(LowLimit) + 1;

  localparam logic [DIV_WIDTH-1:0] MinDiv     = DIV_WIDTH'(MIN_DIV);
  localparam logic [DIV_WIDTH-1:0] DefaultDiv = DIV_WIDTH'(DEFAULT_DIV);
  localparam logic [McntW-1:0]     McntMax    = '1;
  localparam logic [LcntW-1:0]     LowMax     = LcntW'(LowLimit);

  typedef enum logic [2:0] {
    StIdle,
    StWaitHigh,
    StWaitStart,
    StMeasure,
    StWaitStop,
    StApply,
    StFail
  } state_e;

  state_e               state_q, state_d;
  logic [DIV_WIDTH-1:0] divisor_q, divisor_d;
  logic [DIV_WIDTH-1:0] prescaler_q, prescaler_d;
  logic                 locked_q, locked_d;
  logic                 cal_error_q, cal_error_d;
  logic [McntW-1:0]     mcnt_q, mcnt_d;
  logic [2:0]           edge_cnt_q, edge_cnt_d;
  logic [LcntW-1:0]     lcnt_q, lcnt_d;
  logic                 rx_prev_q;
  logic                 div_load;

  logic               fall, rise;
  logic [McntW:0]     mcnt_round;
  logic [DIV_WIDTH:0] div_calc;
  logic               div_ok;

  assign fall = rx_prev_q & ~rx_serial_sync;
  assign rise = ~rx_prev_q & rx_serial_sync;

  // First-to-fifth fall spans 8 bit times of 16 ticks each: divide by 128, rounded.
  assign mcnt_round = {1'b0, mcnt_q} + (McntW + 1)'(64);
  assign div_calc   = mcnt_round[McntW:7];
  assign div_ok     = ~div_calc[DIV_WIDTH] && (div_calc[DIV_WIDTH-1:0] >= MinDiv);

  always_comb begin
    state_d     = state_q;
    divisor_d   = divisor_q;
    locked_d    = locked_q;
    cal_error_d = cal_error_q;
    mcnt_d      = mcnt_q;
    edge_cnt_d  = edge_cnt_q;
    lcnt_d      = lcnt_q;
    div_load    = 1'b0;

    unique case (state_q)
      StIdle: begin
        // A simultaneous div_wr takes priority, so cal_start is dropped.
        if (cal_start && !div_wr) begin
          state_d     = StWaitHigh;
          cal_error_d = 1'b0;
          locked_d    = 1'b0;
        end
      end
      StWaitHigh: begin
        if (rx_serial_sync) state_d = StWaitStart;
      end
      StWaitStart: begin
        if (fall) begin
          state_d    = StMeasure;
          mcnt_d     = McntW'(1);
          edge_cnt_d = 3'd1;
        end
      end
      StMeasure: begin
        if (mcnt_q == McntMax) begin
          state_d = StFail;
        end else if (fall && (edge_cnt_q == 3'd4)) begin
          // mcnt is not bumped on the fifth fall so it equals exactly 8 bit periods.
          state_d    = StWaitStop;
          edge_cnt_d = 3'd5;
          lcnt_d     = '0;
        end else begin
          mcnt_d = mcnt_q + 1'b1;
          if (fall) edge_cnt_d = edge_cnt_q + 3'd1;
        end
      end
      StWaitStop: begin
        if (rise) begin
          state_d = StApply;
        end else if (lcnt_q == LowMax) begin
          state_d = StFail;
        end else begin
          lcnt_d = lcnt_q + 1'b1;
        end
      end
      StApply: begin
        if (div_ok) begin
          divisor_d = div_calc[DIV_WIDTH-1:0];
          locked_d  = 1'b1;
          div_load  = 1'b1;
        end else begin
          cal_error_d = 1'b1;
        end
        state_d = StIdle;
      end
      StFail: begin
        cal_error_d = 1'b1;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // A valid manual write overrides everything, including an ongoing calibration.
    if (div_wr && (div_wdata >= MinDiv)) begin
      divisor_d   = div_wdata;
      locked_d    = 1'b1;
      cal_error_d = 1'b0;
      state_d     = StIdle;
      div_load    = 1'b1;
    end
  end

  always_comb begin
    prescaler_d = prescaler_q + 1'b1;
    if (div_load || (prescaler_q >= divisor_q - 1'b1)) prescaler_d = '0;
  end

  always_ff @(posedge uart_clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      divisor_q   <= DefaultDiv;
      prescaler_q <= '0;
      locked_q    <= 1'b0;
      cal_error_q <= 1'b0;
      mcnt_q      <= '0;
      edge_cnt_q  <= '0;
      lcnt_q      <= '0;
      rx_prev_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      divisor_q   <= divisor_d;
      prescaler_q <= prescaler_d;
      locked_q    <= locked_d;
      cal_error_q <= cal_error_d;
      mcnt_q      <= mcnt_d;
      edge_cnt_q  <= edge_cnt_d;
      lcnt_q      <= lcnt_d;
      rx_prev_q   <= rx_serial_sync;
    end
  end

  assign cal_busy    = (state_q != StIdle);
  assign rx_enable   = ~cal_busy;
  assign sample_tick = (prescaler_q == divisor_q - 1'b1) && ~cal_busy;
  assign divisor     = divisor_q;
  assign locked      = locked_q;
  assign cal_error   = cal_error_q;

endmodule

// File: tb/tb_uart_autobaud.sv
// Self-checking bench for uart_autobaud: table-driven divisor writes and calibrations,
// plus hand-written sequences for abort, priority, timeout and reset corner cases.
// DIV_WIDTH is reduced to 8 so that the measurement counter saturates in ~32k cycles.
module tb_uart_autobaud;

  localparam int unsigned DW = 8;

  logic          uart_clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx_serial_sync = 1'b1;
  logic          cal_start = 1'b0;
  logic          div_wr = 1'b0;
  logic [DW-1:0] div_wdata = '0;
  logic          sample_tick;
  logic [DW-1:0] divisor;
  logic          rx_enable;
  logic          cal_busy;
  logic          locked;
  logic          cal_error;

  uart_autobaud #(
    .DIV_WIDTH  (DW),
    .DEFAULT_DIV(27),
    .MIN_DIV    (4)
  ) dut (
    .uart_clk      (uart_clk),
    .rst           (rst),
    .rx_serial_sync(rx_serial_sync),
    .cal_start     (cal_start),
    .div_wr        (div_wr),
    .div_wdata     (div_wdata),
    .sample_tick   (sample_tick),
    .divisor       (divisor),
    .rx_enable     (rx_enable),
    .cal_busy      (cal_busy),
    .locked        (locked),
    .cal_error     (cal_error)
  );

  always #5 uart_clk = ~uart_clk;

  int checks = 0;
  int passed = 0;

  typedef struct {
    int wdata;
    int exp_div;
    int exp_locked;
  } wr_vec_t;

  typedef struct {
    int period;
    int exp_div;
    int exp_locked;
    int exp_err;
  } cal_vec_t;

  wr_vec_t  wr_tab[7];
  cal_vec_t cal_tab[4];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Advance n clock edges; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge uart_clk);
      #1;
    end
  endtask

  // Edges until sample_tick is seen high; returns limit if it never shows.
  task automatic edges_to_tick(input int limit, output int n);
    n = 0;
    while (1) begin
      step(1);
      n++;
      if (sample_tick || n >= limit) break;
    end
  endtask

  task automatic send_55(input int period);
    logic [9:0] frame;
    frame = {1'b1, 8'h55, 1'b0};
    for (int b = 0; b < 10; b++) begin
      rx_serial_sync = frame[b];
      step(period);
    end
    rx_serial_sync = 1'b1;
  endtask

  task automatic pulse_cal_start();
    cal_start = 1'b1;
    step(1);
    cal_start = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;

    wr_tab[0] = '{3, 27, 0};
    wr_tab[1] = '{50, 50, 1};
    wr_tab[2] = '{4, 4, 1};
    wr_tab[3] = '{3, 4, 1};
    wr_tab[4] = '{0, 4, 1};
    wr_tab[5] = '{255, 255, 1};
    wr_tab[6] = '{27, 27, 1};

    // 8P cycles -> (8P+64)>>7: 160->10, 8->1 (rejected), 434->27, 437->27
    cal_tab[0] = '{160, 10, 1, 0};
    cal_tab[1] = '{8, 10, 0, 1};
    cal_tab[2] = '{434, 27, 1, 0};
    cal_tab[3] = '{437, 27, 1, 0};

    // Reset state
    step(3);
    check("rst_divisor", int'(divisor), 27);
    check("rst_locked", int'(locked), 0);
    check("rst_rx_enable", int'(rx_enable), 1);
    check("rst_cal_busy", int'(cal_busy), 0);
    check("rst_cal_error", int'(cal_error), 0);
    check("rst_tick", int'(sample_tick), 0);
    rst = 1'b0;
    edges_to_tick(100, n);
    check("first_tick_edges", n, 26);
    edges_to_tick(100, n);
    check("tick_period_27", n, 27);

    // Manual divisor writes
    foreach (wr_tab[i]) begin
      div_wdata = DW'(wr_tab[i].wdata);
      div_wr = 1'b1;
      step(1);
      div_wr = 1'b0;
      check($sformatf("wr%0d_divisor", i), int'(divisor), wr_tab[i].exp_div);
      check($sformatf("wr%0d_locked", i), int'(locked), wr_tab[i].exp_locked);
    end
    edges_to_tick(100, n);
    edges_to_tick(100, n);
    check("wr_tick_period", n, 27);

    // Calibrations
    foreach (cal_tab[i]) begin
      pulse_cal_start();
      step(2);
      check($sformatf("cal%0d_busy", i), int'(cal_busy), 1);
      check($sformatf("cal%0d_rx_en_low", i), int'(rx_enable), 0);
      check($sformatf("cal%0d_locked_clr", i), int'(locked), 0);
      check($sformatf("cal%0d_tick_off", i), int'(sample_tick), 0);
      send_55(cal_tab[i].period);
      step(2);
      check($sformatf("cal%0d_done", i), int'(cal_busy), 0);
      check($sformatf("cal%0d_rx_en", i), int'(rx_enable), 1);
      check($sformatf("cal%0d_divisor", i), int'(divisor), cal_tab[i].exp_div);
      check($sformatf("cal%0d_locked", i), int'(locked), cal_tab[i].exp_locked);
      check($sformatf("cal%0d_error", i), int'(cal_error), cal_tab[i].exp_err);
      edges_to_tick(600, n);
      edges_to_tick(600, n);
      check($sformatf("cal%0d_tick_period", i), n, cal_tab[i].exp_div);
    end

    // div_wr of 50 in the middle of MEASURE aborts and restarts the prescaler
    pulse_cal_start();
    step(2);
    rx_serial_sync = 1'b0;
    step(5);
    rx_serial_sync = 1'b1;
    step(5);
    rx_serial_sync = 1'b0;
    step(3);
    check("abort_busy_before", int'(cal_busy), 1);
    div_wdata = DW'(50);
    div_wr = 1'b1;
    step(1);
    div_wr = 1'b0;
    rx_serial_sync = 1'b1;
    check("abort_busy", int'(cal_busy), 0);
    check("abort_divisor", int'(divisor), 50);
    check("abort_locked", int'(locked), 1);
    check("abort_rx_en", int'(rx_enable), 1);
    edges_to_tick(200, n);
    check("abort_first_tick", n, 49);
    edges_to_tick(200, n);
    check("abort_tick_period", n, 50);

    // div_wr and cal_start together: write wins, no calibration
    div_wdata = DW'(40);
    div_wr = 1'b1;
    cal_start = 1'b1;
    step(1);
    div_wr = 1'b0;
    cal_start = 1'b0;
    step(2);
    check("both_busy", int'(cal_busy), 0);
    check("both_divisor", int'(divisor), 40);
    check("both_locked", int'(locked), 1);

    // Line held low after the first fall: mcnt saturates at 2^15-1, then FAIL, then IDLE
    pulse_cal_start();
    step(2);
    rx_serial_sync = 1'b0;
    n = 0;
    while (1) begin
      step(1);
      n++;
      if (!cal_busy || n >= 40000) break;
    end
    rx_serial_sync = 1'b1;
    check("sat_edges", n, 32769);
    check("sat_error", int'(cal_error), 1);
    check("sat_rx_en", int'(rx_enable), 1);
    check("sat_divisor", int'(divisor), 40);
    check("sat_locked", int'(locked), 0);
    step(3);

    // Reset in the middle of MEASURE
    pulse_cal_start();
    step(2);
    rx_serial_sync = 1'b0;
    step(10);
    check("rstm_busy_before", int'(cal_busy), 1);
    rst = 1'b1;
    #1;
    check("rstm_divisor", int'(divisor), 27);
    check("rstm_busy", int'(cal_busy), 0);
    check("rstm_rx_en", int'(rx_enable), 1);
    check("rstm_locked", int'(locked), 0);
    check("rstm_error", int'(cal_error), 0);
    check("rstm_tick", int'(sample_tick), 0);
    rx_serial_sync = 1'b1;
    step(2);
    rst = 1'b0;
    step(1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
